// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states and
// payload field layout used when packing stage control/data into one word.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // EX/MEM payload layout, LSB first
  localparam int unsigned EXMEM_REGWR_BIT    = 0;
  localparam int unsigned EXMEM_MEMTOREG_BIT = 1;
  localparam int unsigned EXMEM_REGWRADDR_LSB = 2;
  localparam int unsigned REGWRADDR_W        = 5;
  localparam int unsigned EXMEM_ALUOUT_LSB   = 7;
  localparam int unsigned ALUOUT_W           = 32;
  localparam int unsigned EXMEM_PC4_LSB      = 39;
  localparam int unsigned PC4_W              = 32;
  localparam int unsigned EXMEM_W            = 71;

  function automatic logic [EXMEM_W-1:0] pack_exmem(
    input logic                   reg_wr,
    input logic                   mem_to_reg,
    input logic [REGWRADDR_W-1:0] reg_wr_addr,
    input logic [ALUOUT_W-1:0]    alu_out,
    input logic [PC4_W-1:0]       pc4
  );
    return {pc4, alu_out, reg_wr_addr, mem_to_reg, reg_wr};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, optional 2-entry skid
// buffer and a saturating stall counter for performance debug.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       SKID_EN   = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  if (SKID_EN != 0) begin : g_skid
    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;
    logic              in_xfer, out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_ready  = ready_q;
    assign in_xfer   = in_valid && ready_q && !flush;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        // ready is registered from the next state so it never depends on out_ready
        ready_q <= (state_d != ST_TWO);
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_d = ST_ONE;
              main_d  = in_data;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              main_d = in_data;
            end else if (in_xfer) begin
              state_d = ST_TWO;
              skid_d  = in_data;
            end else if (out_xfer) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_xfer) begin
              state_d = ST_ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
  end else begin : g_single
    logic              valid_q;
    logic [DATA_W-1:0] main_q;
    logic              in_xfer, out_xfer;

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign in_ready  = !valid_q || out_ready;
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = valid_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (in_xfer) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (out_xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .clr  (cnt_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid variant (CNT_W=4) and a single-entry
// variant share stimulus and are checked against queue-based models.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV_S = 32'h0;
  localparam logic [31:0] RV_N = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush, cnt_clr;
  logic [31:0] in_data;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [3:0]  s_cnt;
  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_data;
  logic [15:0] n_cnt;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [31:0] qs[$];
  logic [31:0] qn[$];
  logic [31:0] hold_s, hold_n;
  int          cnt_s, cnt_n;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32), .RESET_VAL(RV_S), .SKID_EN(1), .CNT_W(4)
  ) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .flush(flush), .stall_cnt(s_cnt), .cnt_clr(cnt_clr)
  );

  pipe_stage_reg #(
    .DATA_W(32), .RESET_VAL(RV_N), .SKID_EN(0), .CNT_W(16)
  ) u_single (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_data(n_out_data), .flush(flush), .stall_cnt(n_cnt), .cnt_clr(cnt_clr)
  );

  task automatic model_reset();
    qs.delete();
    qn.delete();
    hold_s = RV_S;
    hold_n = RV_N;
    cnt_s  = 0;
    cnt_n  = 0;
  endtask

  // Advance the models by one clock using the inputs currently applied,
  // then let the DUTs take the same edge.
  task automatic step();
    bit rs, rn;
    rs = (qs.size() < 2);
    rn = (qn.size() == 0) || out_ready;
    if (cnt_clr) cnt_s = 0;
    else if (qs.size() > 0 && !out_ready && cnt_s < 15) cnt_s++;
    if (cnt_clr) cnt_n = 0;
    else if (qn.size() > 0 && !out_ready && cnt_n < 65535) cnt_n++;
    if (flush) begin
      qs.delete();
      qn.delete();
    end else begin
      if (qs.size() > 0 && out_ready) void'(qs.pop_front());
      if (in_valid && rs) qs.push_back(in_data);
      if (qn.size() > 0 && out_ready) void'(qn.pop_front());
      if (in_valid && rn) qn.push_back(in_data);
    end
    @(posedge clk);
    #1;
    if (qs.size() > 0) hold_s = qs[0];
    if (qn.size() > 0) hold_n = qn[0];
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 32'hDEAD_BEEF)
      $display("FAIL reset_pre: got v=%b d=%h want v=1 d=deadbeef", s_out_valid, s_out_data);
    else passed++;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({s_out_valid, s_out_data, s_cnt, s_in_ready} !== {1'b0, 32'h0, 4'h0, 1'b1})
      $display("FAIL reset_async_skid: got v=%b d=%h c=%h r=%b want v=0 d=0 c=0 r=1",
               s_out_valid, s_out_data, s_cnt, s_in_ready);
    else passed++;
    checks++;
    if ({n_out_valid, n_out_data, n_cnt, n_in_ready} !== {1'b0, RV_N, 16'h0, 1'b1})
      $display("FAIL reset_async_single: got v=%b d=%h c=%h r=%b want v=0 d=%h c=0 r=1",
               n_out_valid, n_out_data, n_cnt, n_in_ready, RV_N);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1 || s_out_valid !== 1'b0)
      $display("FAIL reset_release: got s_r=%b n_r=%b s_v=%b want 1 1 0",
               s_in_ready, n_in_ready, s_out_valid);
    else passed++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      checks++;
      if ({s_out_valid, s_out_data, s_in_ready, s_cnt} !== {1'b1, 32'(i), 1'b1, 4'h0})
        $display("FAIL stream_skid[%0d]: got v=%b d=%h r=%b c=%h want v=1 d=%h r=1 c=0",
                 i, s_out_valid, s_out_data, s_in_ready, s_cnt, i);
      else passed++;
      checks++;
      if ({n_out_valid, n_out_data, n_in_ready, n_cnt} !== {1'b1, 32'(i), 1'b1, 16'h0})
        $display("FAIL stream_single[%0d]: got v=%b d=%h r=%b c=%h want v=1 d=%h r=1 c=0",
                 i, n_out_valid, n_out_data, n_in_ready, n_cnt, i);
      else passed++;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if ({s_out_valid, s_out_data, n_out_valid, n_out_data} !== {1'b0, 32'h4, 1'b0, 32'h4})
      $display("FAIL bubble_drain: got s_v=%b s_d=%h n_v=%b n_d=%h want 0 4 0 4",
               s_out_valid, s_out_data, n_out_valid, n_out_data);
    else passed++;
  endtask

  task automatic test_back_pressure();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    checks++;
    if ({s_in_ready, s_out_valid, s_out_data} !== {1'b0, 1'b1, 32'h11})
      $display("FAIL bp_two: got r=%b v=%b d=%h want r=0 v=1 d=11",
               s_in_ready, s_out_valid, s_out_data);
    else passed++;
    in_valid = 1'b0;
    repeat (2) step();
    checks++;
    if (s_cnt !== 4'd3 || n_cnt !== 16'd3)
      $display("FAIL bp_stall_cnt: got s=%0d n=%0d want 3 3", s_cnt, n_cnt);
    else passed++;
    out_ready = 1'b1;
    step();
    checks++;
    if ({s_out_valid, s_out_data, s_in_ready} !== {1'b1, 32'h22, 1'b1})
      $display("FAIL bp_second: got v=%b d=%h r=%b want v=1 d=22 r=1",
               s_out_valid, s_out_data, s_in_ready);
    else passed++;
    step();
    checks++;
    if ({s_out_valid, s_out_data, n_out_valid, n_out_data} !== {1'b0, 32'h22, 1'b0, 32'h11})
      $display("FAIL bp_drained: got s_v=%b s_d=%h n_v=%b n_d=%h want 0 22 0 11",
               s_out_valid, s_out_data, n_out_valid, n_out_data);
    else passed++;
  endtask

  task automatic test_comb_ready();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      out_ready = k[0];
      #1;
      checks++;
      if (n_in_ready !== k[0])
        $display("FAIL comb_ready[%0d]: got %b want %b", k, n_in_ready, k[0]);
      else passed++;
    end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if ({n_out_valid, n_out_data} !== {1'b0, 32'h55})
      $display("FAIL single_no_second: got v=%b d=%h want v=0 d=55", n_out_valid, n_out_data);
    else passed++;
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA1; step();
    in_data = 32'hA2; step();
    flush = 1'b1; in_data = 32'h33;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({s_out_valid, s_in_ready, s_out_data} !== {1'b0, 1'b1, 32'hA1})
      $display("FAIL flush_skid: got v=%b r=%b d=%h want v=0 r=1 d=a1",
               s_out_valid, s_in_ready, s_out_data);
    else passed++;
    checks++;
    if ({n_out_valid, n_out_data} !== {1'b0, 32'hA1})
      $display("FAIL flush_single: got v=%b d=%h want v=0 d=a1", n_out_valid, n_out_data);
    else passed++;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (s_out_valid !== 1'b0 || s_out_data === 32'h33 || n_out_valid !== 1'b0)
        $display("FAIL flush_dropped: got s_v=%b s_d=%h n_v=%b want 0 !=33 0",
                 s_out_valid, s_out_data, n_out_valid);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    drain();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; step();
    in_valid = 1'b0;
    repeat (20) step();
    checks++;
    if (s_cnt !== 4'd15 || n_cnt !== 16'd20)
      $display("FAIL sat_cnt: got s=%0d n=%0d want 15 20", s_cnt, n_cnt);
    else passed++;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    checks++;
    if (s_cnt !== 4'd0 || n_cnt !== 16'd0)
      $display("FAIL cnt_clr: got s=%0d n=%0d want 0 0", s_cnt, n_cnt);
    else passed++;
    step();
    checks++;
    if (s_cnt !== 4'd1 || n_cnt !== 16'd1)
      $display("FAIL cnt_after_clr: got s=%0d n=%0d want 1 1", s_cnt, n_cnt);
    else passed++;
    drain();
  endtask

  task automatic test_random();
    logic [37:0] es, as;
    logic [49:0] en, an;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cnt_clr   = ($urandom_range(0, 29) == 0);
      step();
      es = {qs.size() < 2, qs.size() != 0, hold_s, 4'(cnt_s)};
      as = {s_in_ready, s_out_valid, s_out_data, s_cnt};
      en = {(qn.size() == 0) || out_ready, qn.size() != 0, hold_n, 16'(cnt_n)};
      an = {n_in_ready, n_out_valid, n_out_data, n_cnt};
      checks++;
      if (as !== es)
        $display("FAIL random_skid[%0d]: got %h want %h (ready,valid,data,cnt)", i, as, es);
      else passed++;
      checks++;
      if (an !== en)
        $display("FAIL random_single[%0d]: got %h want %h (ready,valid,data,cnt)", i, an, en);
      else passed++;
    end
    flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_comb_ready();
    test_flush();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register. It generalises the fixed-field inter-stage latch into a DATA_W-wide stage with valid/ready handshaking, stall back-pressure, synchronous flush and an optional 2-entry skid buffer. It sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The per-stage control and data fields are packed into one payload word by the instantiating stage. A saturating stall counter is included for performance debug.

Parameters:
DATA_W, 32, payload width in bits (1..256)
RESET_VAL, 0, payload value loaded on reset (DATA_W bits)
SKID_EN, 1, 1 = 2-entry skid buffer (in_ready is registered); 0 = single entry (in_ready is combinational from out_ready)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  registered payload
flush  in  1  synchronous kill of all held entries
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset: applied asynchronously, effective immediately. out_valid=0, skid entry invalid, out_data=RESET_VAL, skid data=RESET_VAL, stall_cnt=0. in_ready=1 while rst is high and after release.
- Handshake: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready. out_data is stable while out_valid && !out_ready.
- Latency: one cycle from an accepted input to out_valid. There is no combinational path from in_data to out_data.
- SKID_EN=0:
  - in_ready = !out_valid || out_ready.
  - On an input transfer, the main register loads in_data and out_valid=1.
  - On an output transfer with no input transfer, out_valid=0.
- SKID_EN=1, states EMPTY, ONE, TWO (TWO = main and skid both full):
  - in_ready = (state != TWO), driven from a register.
  - EMPTY + in xfer -> ONE; main register loads in_data.
  - ONE + in xfer + out xfer -> ONE; main register loads in_data.
  - ONE + in xfer only -> TWO; skid register loads in_data.
  - ONE + out xfer only -> EMPTY.
  - TWO + out xfer -> ONE; main register loads skid data.
  - TWO: no input transfer is possible.
  - Order is preserved: skid data always leaves after main data.
- Flush:
  - Has priority over every transfer in the same cycle. The input offered that cycle is dropped and not accepted.
  - Next cycle: out_valid=0, skid invalid, state=EMPTY. out_data holds its old value (not RESET_VAL).
  - An output transfer coincident with flush still counts as completed downstream.
- Bubble: when in_valid=0, the stage drains and no payload is duplicated.
- Data width: payload is passed bit-exact. No field is interpreted.
- Stall counter:
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority over increment and sets the counter to 0 the next cycle.
  - Flush does not clear the counter.
- Reset mid-operation: all held entries are discarded with no partial outputs. The first cycle after release behaves as EMPTY.

Decomposition:
- Shared package: stage-state encoding constants (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and the payload field offsets each stage uses (RegWr, MemtoReg, RegWrAddr, ALUOut, PC4, etc.) for packing and unpacking.
- One sub-module: sat_counter (CNT_W, inc, clr) for stall_cnt.
- The skid logic stays inline, guarded by generate on SKID_EN.

Test Plan:
1. Reset: assert rst mid-stream with out_valid=1, out_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, stall_cnt=0 immediately. in_ready=1 after release.
2. Streaming: out_ready=1, in_valid=1, feed in_data 1,2,3,4 in consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready constant 1, stall_cnt stays 0.
3. Back-pressure (SKID_EN=1): send A=0x11 then B=0x22, hold out_ready=0 -> state TWO and in_ready=0 the cycle after B is accepted. Then raise out_ready -> outputs 0x11 then 0x22 with no loss and no duplicate. stall_cnt equals the number of stalled cycles.
4. SKID_EN=0 combinational ready: out_valid=1, out_ready toggled 0/1 -> in_ready follows !out_valid||out_ready in the same cycle. No second entry is held.
5. Flush in TWO with in_valid=1, in_data=0x33 -> next cycle out_valid=0, in_ready=1, 0x33 never appears on the output. out_data still shows the old main value.
6. Counter saturation (CNT_W=4): stall 20 cycles -> stall_cnt=15. Pulse cnt_clr together with a stall -> stall_cnt=0 next cycle.
